// File: rtl/comp_argsel_ctrl.sv
// Argmax/argmin sequencer: streams a list of unsigned operands through one shared
// external greater-than comparator and keeps the running best value and its index.
module comp_argsel_ctrl #(
    parameter int WIDTH = 64,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] count,
    input  logic             sel_min,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic             cmp_gt,
    output logic             busy,
    output logic             done,
    output logic             empty,
    output logic [WIDTH-1:0] best_val,
    output logic [IDX_W-1:0] best_idx
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FIRST = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_count;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_best_idx;
    logic [WIDTH-1:0] r_best_val;
    logic             r_sel_min;
    logic             r_empty;

    logic             w_run;
    logic             w_hs;
    logic             w_last;

    assign w_run    = (r_state == S_RUN);
    assign in_ready = (r_state == S_FIRST) || w_run;
    assign w_hs     = in_valid & in_ready;
    assign w_last   = (r_cnt == (r_count - IDX_ONE));

    // Operand order is swapped for argmin so the single x_a > x_b cell serves both modes.
    assign cmp_a = !w_run ? '0 : (r_sel_min ? r_best_val : in_data);
    assign cmp_b = !w_run ? '0 : (r_sel_min ? in_data : r_best_val);

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign empty    = done & r_empty;
    assign best_val = r_best_val;
    assign best_idx = r_best_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_cnt      <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
            r_sel_min  <= 1'b0;
            r_empty    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count   <= count;
                        r_sel_min <= sel_min;
                        r_cnt     <= '0;
                        r_empty   <= (count == '0);
                        if (count == '0) begin
                            r_best_val <= '0;
                            r_best_idx <= '0;
                            r_state    <= S_DONE;
                        end else begin
                            r_state    <= S_FIRST;
                        end
                    end
                end
                S_FIRST: begin
                    if (w_hs) begin
                        r_best_val <= in_data;
                        r_best_idx <= '0;
                        r_cnt      <= IDX_ONE;
                        r_state    <= (r_count == IDX_ONE) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        // Strict compare: equal values never replace, so the earliest index wins.
                        if (cmp_gt) begin
                            r_best_val <= in_data;
                            r_best_idx <= r_cnt;
                        end
                        r_cnt <= r_cnt + IDX_ONE;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
